// File: rtl/ddr3_rw_pkg.sv
// Shared definitions for the DDR3 burst read/write engines on the MIG native app interface.
// Holds the MIG command encodings and the common burst FSM state type.
package ddr3_rw_pkg;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CMD       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } rw_state_t;

endpackage

// File: rtl/ddr3_burst_rd.sv
// Burst-read engine: issues MIG read commands for one user burst, throttled by the
// number of outstanding commands, and forwards returned beats as a registered stream.
module ddr3_burst_rd
    import ddr3_rw_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 28,
    parameter int ADDR_STEP       = 16,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_burst_start,
    input  logic [ADDR_WIDTH-1:0] rd_burst_len,
    input  logic [ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [DATA_WIDTH-1:0] rd_burst_data,
    output logic                  rd_burst_data_valid,
    output logic                  rd_burst_done,
    output logic                  rd_burst_busy,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    input  logic                  app_rd_data_end
);

    localparam logic [ADDR_WIDTH-1:0] MAX_OUT  = ADDR_WIDTH'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    rw_state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] len_reg;
    logic [ADDR_WIDTH-1:0] cmd_cnt_reg;
    logic [ADDR_WIDTH-1:0] data_cnt_reg;
    logic [ADDR_WIDTH-1:0] app_addr_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  done_reg;
    logic                  busy_reg;

    logic [ADDR_WIDTH-1:0] outstanding;
    logic                  start_accept;
    logic                  cmd_fire;
    logic                  last_cmd;
    logic                  beat_accept;
    logic                  last_beat;

    // app_rd_data_end mirrors app_rd_data_valid at 4:1, so it carries no extra information.
    logic unused_rd_data_end;
    assign unused_rd_data_end = app_rd_data_end;

    assign outstanding  = cmd_cnt_reg - data_cnt_reg;
    assign start_accept = (state_reg == ST_IDLE) && rd_burst_start;
    assign app_en       = (state_reg == ST_CMD) && (outstanding < MAX_OUT);
    assign cmd_fire     = app_en && app_rdy;
    assign last_cmd     = (cmd_cnt_reg == len_reg - ONE);

    // Beats are only taken while a burst is collecting and never beyond its length.
    assign beat_accept  = app_rd_data_valid
                          && ((state_reg == ST_CMD) || (state_reg == ST_WAIT_DATA))
                          && (data_cnt_reg != len_reg);
    assign last_beat    = beat_accept && (data_cnt_reg == len_reg - ONE);

    assign app_cmd             = MIG_CMD_READ;
    assign app_addr            = app_addr_reg;
    assign rd_burst_data       = rd_data_reg;
    assign rd_burst_data_valid = rd_valid_reg;
    assign rd_burst_done       = done_reg;
    assign rd_burst_busy       = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_burst_start) begin
                    state_next = (rd_burst_len == '0) ? ST_DONE : ST_CMD;
                end
            end
            ST_CMD: begin
                if (last_beat) begin
                    state_next = ST_DONE;
                end else if (cmd_fire && last_cmd) begin
                    state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (last_beat) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_reg      <= '0;
            cmd_cnt_reg  <= '0;
            data_cnt_reg <= '0;
            app_addr_reg <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= beat_accept;
            done_reg     <= (state_next == ST_DONE);
            busy_reg     <= (state_next != ST_IDLE);

            if (beat_accept) begin
                rd_data_reg <= app_rd_data;
            end

            if (start_accept) begin
                len_reg      <= rd_burst_len;
                app_addr_reg <= rd_burst_addr;
                cmd_cnt_reg  <= '0;
                data_cnt_reg <= '0;
            end else begin
                // Command and data may retire in the same cycle; both counters move.
                if (cmd_fire) begin
                    cmd_cnt_reg  <= cmd_cnt_reg + ONE;
                    app_addr_reg <= app_addr_reg + STEP;
                end
                if (beat_accept) begin
                    data_cnt_reg <= data_cnt_reg + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_burst_rd.sv
// Directed bench for ddr3_burst_rd: a table of bursts run against a small MIG
// read-return model, plus hand-written reset sequences.
module tb_ddr3_burst_rd;
    import ddr3_rw_pkg::*;

    localparam int DW   = 128;
    localparam int AW   = 28;
    localparam int STEP = 16;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_burst_start;
    logic [AW-1:0] rd_burst_len;
    logic [AW-1:0] rd_burst_addr;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_data_valid;
    logic          rd_burst_done;
    logic          rd_burst_busy;
    logic          app_en;
    logic          app_rdy;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;

    always #5 clk = ~clk;
    assign app_rd_data_end = app_rd_data_valid;

    ddr3_burst_rd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_STEP(STEP), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_burst_start(rd_burst_start), .rd_burst_len(rd_burst_len),
        .rd_burst_addr(rd_burst_addr), .rd_burst_data(rd_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_done(rd_burst_done),
        .rd_burst_busy(rd_burst_busy), .app_en(app_en), .app_rdy(app_rdy),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        int            lat;
        int            stall_idx;
        int            stall_len;
        bit            mid_start;
        logic [AW-1:0] exp_last_addr;
        int            exp_cmds;
        int            exp_beats;
        int            exp_busy;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } ret_t;

    ret_t rq[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        return {32'hCAFE0000 ^ {4'h0, a}, 64'h0123_4567_89AB_CDEF, 4'h5, a};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_app_en"},   {127'b0, app_en}, '0);
        chk({tag, "_app_addr"}, {100'b0, app_addr}, '0);
        chk({tag, "_data"},     rd_burst_data, '0);
        chk({tag, "_valid"},    {127'b0, rd_burst_data_valid}, '0);
        chk({tag, "_done"},     {127'b0, rd_burst_done}, '0);
        chk({tag, "_busy"},     {127'b0, rd_burst_busy}, '0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int hs = 0, beats = 0, dones = 0, busy_cyc = 0, beat_in = 0;
        int stall_left = v.stall_len, after = 0, max_o_en = 0, o;
        bit got_done = 0, hold_prev = 0;
        logic [AW-1:0] last_addr = '0;
        logic [AW-1:0] ea;
        rq.delete();
        @(negedge clk); cyc++;
        rd_burst_start = 1'b1; rd_burst_addr = v.addr; rd_burst_len = v.len;
        app_rd_data_valid = 1'b0; app_rdy = 1'b1;
        for (int k = 0; k < 600 && after < 2; k++) begin
            @(negedge clk); cyc++;
            // observe outputs produced by the previous rising edge
            if (k == 0) chk("busy_after_start", {127'b0, rd_burst_busy}, 1);
            if (rd_burst_busy) busy_cyc++;
            if (got_done) begin
                after++;
                if (after == 1) begin
                    chk("idle_after_done_busy", {127'b0, rd_burst_busy}, 0);
                    chk("idle_after_done_en", {127'b0, app_en}, 0);
                end else begin
                    chk("stray_idle_beat", {127'b0, rd_burst_data_valid}, 0);
                end
            end
            if (rd_burst_data_valid && !got_done) begin
                if (beats < int'(v.len)) begin
                    ea = v.addr + AW'(beats * STEP);
                    chk("beat_data", rd_burst_data, mk_data(ea));
                end else begin
                    chk("extra_beat", beats, v.len);
                end
                beats++;
                chk("done_on_last_beat", {127'b0, rd_burst_done}, {127'b0, beats == int'(v.len)});
            end
            if (rd_burst_done) begin
                dones++;
                if (v.len == '0) chk("zero_len_done_cycle", k, 0);
                else chk("done_without_beat", {127'b0, rd_burst_data_valid}, 1);
                got_done = 1;
            end
            if (hold_prev) begin
                ea = v.addr + AW'(hs * STEP);
                chk("hold_app_en", {127'b0, app_en}, 1);
                chk("hold_app_addr", {100'b0, app_addr}, {100'b0, ea});
            end
            o = hs - beat_in;
            if (app_en && o > max_o_en) max_o_en = o;
            // drive inputs for the next rising edge
            rd_burst_start = 1'b0;
            if (v.mid_start && k == 2) begin
                rd_burst_start = 1'b1; rd_burst_addr = 28'h0AA0; rd_burst_len = 28'd3;
            end
            if (got_done && after == 0) begin
                rd_burst_start = 1'b1; rd_burst_addr = 28'h0BB0; rd_burst_len = 28'd5;
            end
            app_rdy = 1'b1;
            if (app_en && hs == v.stall_idx && stall_left > 0) begin
                app_rdy = 1'b0;
                stall_left--;
            end
            hold_prev = app_en && !app_rdy;
            if (app_en && app_rdy) begin
                ea = v.addr + AW'(hs * STEP);
                chk("cmd_addr", {100'b0, app_addr}, {100'b0, ea});
                rq.push_back('{cyc + v.lat, mk_data(app_addr)});
                last_addr = app_addr;
                hs++;
            end
            if (got_done && after == 1) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = mk_data(28'h0DEAD);
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = rq[0].d;
                rq.delete(0);
                beat_in++;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        app_rd_data_valid = 1'b0;
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL burst%0d_timeout actual=no_done required=done", idx);
        end
        chk("app_cmd", {125'b0, app_cmd}, {125'b0, MIG_CMD_READ});
        chk("cmd_count", hs, v.exp_cmds);
        chk("beat_count", beats, v.exp_beats);
        chk("done_count", dones, 1);
        chk("throttle", {127'b0, max_o_en < MAXO}, 1);
        if (v.exp_cmds > 0) chk("last_cmd_addr", {100'b0, last_addr}, {100'b0, v.exp_last_addr});
        if (v.exp_busy >= 0) chk("busy_cycles", busy_cyc, v.exp_busy);
        $display("burst %0d addr=%h len=%0d cmds=%0d beats=%0d dones=%0d busy_cycles=%0d",
                 idx, v.addr, v.len, hs, beats, dones, busy_cyc);
    endtask

    vec_t vecs[6];

    initial begin
        int hs, pend, stray_seen;
        vecs[0] = '{28'h0000100, 28'd4, 3,  -1, 0, 1'b0, 28'h0000130, 4, 4, -1};
        vecs[1] = '{28'h0000100, 28'd4, 3,   1, 5, 1'b0, 28'h0000130, 4, 4, -1};
        vecs[2] = '{28'h0002000, 28'd8, 20, -1, 0, 1'b0, 28'h0002070, 8, 8, -1};
        vecs[3] = '{28'h0000500, 28'd0, 3,  -1, 0, 1'b0, 28'h0000000, 0, 0,  1};
        vecs[4] = '{28'hFFFFFF0, 28'd2, 3,  -1, 0, 1'b1, 28'h0000000, 2, 2, -1};
        vecs[5] = '{28'h0000040, 28'd1, 1,  -1, 0, 1'b0, 28'h0000040, 1, 1, -1};

        rst_n = 1'b0; rd_burst_start = 1'b0; rd_burst_len = '0; rd_burst_addr = '0;
        app_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset mid-burst after three of six commands have been accepted.
        @(negedge clk);
        rd_burst_start = 1'b1; rd_burst_addr = 28'h0000300; rd_burst_len = 28'd6;
        hs = 0; pend = 0;
        for (int k = 0; k < 100 && hs < 3; k++) begin
            @(negedge clk);
            rd_burst_start = 1'b0;
            app_rdy = 1'b1;
            app_rd_data_valid = (pend > 0);
            app_rd_data = mk_data(28'h0000300);
            if (pend > 0) pend--;
            if (app_en) begin hs++; pend++; end
        end
        chk("pre_reset_cmds", hs, 3);
        @(negedge clk);
        rst_n = 1'b0; app_rd_data_valid = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        stray_seen = 0;
        for (int k = 0; k < 5; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = mk_data(AW'(28'h0000330 + k * STEP));
            @(negedge clk);
            if (rd_burst_data_valid || rd_burst_busy || app_en) stray_seen++;
        end
        app_rd_data_valid = 1'b0;
        chk("stray_after_reset", stray_seen, 0);
        $display("reset_mid_burst cmds_before_reset=%0d stray_outputs=%0d", hs, stray_seen);

        run_vec(vecs[0], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
